// File: rtl/ct_f_spsram_1024x64_req.sv
// Request-side controller for the ct_f_spsram_1024x64 single-port array.
// Clears the whole array after reset. Then it maps a valid/ready request stream
// onto the SRAM's active-low CEN/GWEN/WEN pins and returns read data through a
// one-entry response register.
module ct_f_spsram_1024x64_req #(
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_bwe,
    output logic                    rsp_vld,
    input  logic                    rsp_rdy,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done,
    output logic [ADDR_WIDTH-1:0]   A,
    output logic                    CEN,
    output logic                    GWEN,
    output logic [DATA_WIDTH-1:0]   WEN,
    output logic [DATA_WIDTH-1:0]   D,
    input  logic [DATA_WIDTH-1:0]   Q
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StInit, StIdle, StRdWait, StRsp} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  init_done_q, init_done_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rd_acc, wr_acc;

    assign init_done = init_done_q;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_rdata = rsp_rdata_q;

    // Handshake qualification; RST gates it so no request slips in during reset.
    always_comb begin
        req_rdy = !RST && init_done_q && (state_q != StRdWait) && (!rsp_vld_q || rsp_rdy);
        rd_acc  = req_vld && req_rdy && !req_wr;
        wr_acc  = req_vld && req_rdy && req_wr;
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            addr_q      <= '0;
            init_done_q <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            init_done_q <= init_done_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state logic: init sweep, read launch, response hold and release.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rsp_vld_d   = rsp_vld_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end
            end
            StIdle: begin
                if (rd_acc) state_d = StRdWait;
            end
            StRdWait: begin
                // Q is valid this cycle for the read launched last cycle.
                rsp_rdata_d = Q;
                rsp_vld_d   = 1'b1;
                state_d     = StRsp;
            end
            StRsp: begin
                if (rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                    state_d   = rd_acc ? StRdWait : StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // SRAM pin drive: init write, accepted write/read, otherwise idle with A held.
    always_comb begin
        CEN    = 1'b1;
        GWEN   = 1'b1;
        WEN    = '1;
        D      = '0;
        A      = addr_q;
        if (RST) begin
            A = '0;
        end else if (state_q == StInit) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
            A    = cnt_q;
            D    = INIT_VALUE;
        end else if (wr_acc) begin
            // All-zero mask still takes the access but writes nothing.
            CEN  = 1'b0;
            GWEN = ~|req_bwe;
            for (int unsigned b = 0; b < NumBytes; b++) begin
                WEN[b*8 +: 8] = {8{~req_bwe[b]}};
            end
            A    = req_addr;
            D    = req_wdata;
        end else if (rd_acc) begin
            CEN = 1'b0;
            A   = req_addr;
        end
        addr_d = A;
    end

endmodule

// File: tb/tb_ct_f_spsram_1024x64_req.sv
// Directed bench for ct_f_spsram_1024x64_req with a behavioural SRAM on the pins.
module tb_ct_f_spsram_1024x64_req;

    logic        clk;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic [9:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_bwe;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [63:0] rsp_rdata;
    logic        init_done;
    logic [9:0]  a;
    logic        cen;
    logic        gwen;
    logic [63:0] wen;
    logic [63:0] d;
    logic [63:0] q;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    ct_f_spsram_1024x64_req dut (
        .CLK       (clk),
        .RST       (rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_bwe   (req_bwe),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .A         (a),
        .CEN       (cen),
        .GWEN      (gwen),
        .WEN       (wen),
        .D         (d),
        .Q         (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM: per-bit active-low write, registered read.
    logic [63:0] mem [1024];
    initial q = '0;
    always @(posedge clk) begin
        if (!cen) begin
            if (!gwen) mem[a] <= (mem[a] & wen) | (d & ~wen);
            else       q      <= mem[a];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Read with rsp_rdy high: accept in N, response at N+2, handshake at end of N+2.
    task automatic do_read(input logic [9:0] addr, input logic [63:0] exp, input string tag);
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = addr;
        #1;
        check_eq({tag, "_rdy"}, req_rdy, 1'b1);
        check_eq({tag, "_cen"}, cen, 1'b0);
        check_eq({tag, "_gwen"}, gwen, 1'b1);
        check_eq({tag, "_a"}, a, addr);
        step;
        req_vld = 1'b0;
        #1;
        check_eq({tag, "_vld_n1"}, rsp_vld, 1'b0);
        step;
        #1;
        check_eq({tag, "_vld_n2"}, rsp_vld, 1'b1);
        check_eq({tag, "_data"}, rsp_rdata, exp);
        step;
    endtask

    task automatic do_write(input logic [9:0] addr, input logic [63:0] data, input logic [7:0] bwe,
                            input logic exp_gwen, input logic [63:0] exp_wen, input string tag);
        req_vld   = 1'b1;
        req_wr    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_bwe   = bwe;
        #1;
        check_eq({tag, "_rdy"}, req_rdy, 1'b1);
        check_eq({tag, "_cen"}, cen, 1'b0);
        check_eq({tag, "_gwen"}, gwen, exp_gwen);
        check_eq({tag, "_wen"}, wen, exp_wen);
        check_eq({tag, "_d"}, d, data);
        step;
        req_vld = 1'b0;
        req_wr  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_vld   = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_bwe   = '0;
        rsp_rdy   = 1'b1;

        // Reset values.
        repeat (3) step;
        #1;
        check_eq("rst_cen", cen, 1'b1);
        check_eq("rst_gwen", gwen, 1'b1);
        check_eq("rst_wen", wen, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("rst_a", a, 10'd0);
        check_eq("rst_d", d, 64'd0);
        check_eq("rst_rdy", req_rdy, 1'b0);
        check_eq("rst_done", init_done, 1'b0);
        check_eq("rst_vld", rsp_vld, 1'b0);
        check_eq("rst_rdata", rsp_rdata, 64'd0);

        // Init sweep.
        rst = 1'b0;
        #1;
        check_eq("init0_a", a, 10'd0);
        check_eq("init0_cen", cen, 1'b0);
        check_eq("init0_gwen", gwen, 1'b0);
        check_eq("init0_wen", wen, 64'd0);
        check_eq("init0_rdy", req_rdy, 1'b0);
        repeat (1023) step;
        #1;
        check_eq("init_last_a", a, 10'd1023);
        check_eq("init_last_done", init_done, 1'b0);
        step;
        #1;
        check_eq("init_done", init_done, 1'b1);
        check_eq("idle_rdy", req_rdy, 1'b1);
        check_eq("idle_cen", cen, 1'b1);
        check_eq("idle_a_hold", a, 10'd1023);

        do_read(10'd0, 64'd0, "rd0");
        do_read(10'd1023, 64'd0, "rd1023");
        do_read(10'd517, 64'd0, "rd517");
        #1;
        check_eq("hold_a517", a, 10'd517);
        check_eq("hold_cen", cen, 1'b1);

        // Full write, then byte-masked write, then no-op write.
        do_write(10'd5, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 64'd0, "wr_full");
        do_read(10'd5, 64'h0123_4567_89AB_CDEF, "rd_full");
        do_write(10'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 1'b0, 64'h00FF_FFFF_FFFF_FF00, "wr_mask");
        do_read(10'd5, 64'hFF23_4567_89AB_CDFF, "rd_mask");
        do_write(10'd5, 64'h0000_0000_0000_0000, 8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "wr_nop");
        do_read(10'd5, 64'hFF23_4567_89AB_CDFF, "rd_nop");

        // Backpressure.
        rsp_rdy  = 1'b0;
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = 10'd5;
        step;
        req_vld = 1'b0;
        step;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("bp_vld", rsp_vld, 1'b1);
            check_eq("bp_data", rsp_rdata, 64'hFF23_4567_89AB_CDFF);
            check_eq("bp_rdy", req_rdy, 1'b0);
            step;
        end
        rsp_rdy  = 1'b1;
        req_vld  = 1'b1;
        req_addr = 10'd0;
        #1;
        check_eq("bp_hs_vld", rsp_vld, 1'b1);
        check_eq("bp_hs_rdy", req_rdy, 1'b1);
        check_eq("bp_hs_cen", cen, 1'b0);
        check_eq("bp_hs_a", a, 10'd0);
        step;
        req_vld = 1'b0;
        #1;
        check_eq("bp_next_vld_n1", rsp_vld, 1'b0);
        step;
        #1;
        check_eq("bp_next_vld_n2", rsp_vld, 1'b1);
        check_eq("bp_next_data", rsp_rdata, 64'd0);

        // Reset while a response is pending.
        rsp_rdy = 1'b0;
        rst     = 1'b1;
        #1;
        check_eq("rstp_rdy", req_rdy, 1'b0);
        check_eq("rstp_cen", cen, 1'b1);
        step;
        #1;
        check_eq("rstp_vld", rsp_vld, 1'b0);
        check_eq("rstp_done", init_done, 1'b0);
        rst     = 1'b0;
        rsp_rdy = 1'b1;
        #1;
        check_eq("rstp_init_a", a, 10'd0);
        check_eq("rstp_init_cen", cen, 1'b0);

        // Reset in the middle of the init sweep.
        repeat (300) step;
        #1;
        check_eq("mid_a300", a, 10'd300);
        rst = 1'b1;
        step;
        rst = 1'b0;
        #1;
        check_eq("mid_restart_a", a, 10'd0);
        check_eq("mid_restart_cen", cen, 1'b0);
        check_eq("mid_done0", init_done, 1'b0);
        repeat (1023) step;
        #1;
        check_eq("mid_last_a", a, 10'd1023);
        check_eq("mid_last_done", init_done, 1'b0);
        step;
        #1;
        check_eq("mid_done1", init_done, 1'b1);

        // Full re-clear wipes the earlier write.
        do_read(10'd5, 64'd0, "rd_recleared");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
